mem_boot_ctrl: RTL and testbench
================================

Name: mem_boot_ctrl

Overview:
- Synthesizable sequencer that owns the instruction and data memories around noobs_cpu for the whole run.
- Loads a host byte stream into imem, then into dmem starting at DMEM_BASE.
- Holds the CPU in reset through a cool-off period, runs the CPU until it halts, then streams dmem contents back out to the host.
- Arbitrates the dmem port: the CPU owns it only in RUN; the controller owns it in every other state.

Parameters:
ADDR_W, 12, memory address width
DATA_W, 8, memory data width
DMEM_BASE, 8, first dmem address used for load and dump (addresses 0-7 are special purpose)
DMEM_LIMIT, 2048, dump end address, exclusive
COOLOFF, 32, cycles between load completion and CPU reset release

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  begin a load/run/dump session; sampled in IDLE and DONE only
imem_len  in  ADDR_W  number of instruction bytes to load
dmem_len  in  ADDR_W  number of data bytes to load
in_valid  in  1  host load byte valid
in_data  in  DATA_W  host load byte
in_ready  out  1  controller accepts the load byte
out_valid  out  1  dump byte valid
out_data  out  DATA_W  dump byte
out_ready  in  1  host accepts the dump byte
imem_addr  out  ADDR_W  instruction memory write address
imem_wdata  out  DATA_W  instruction memory write data
imem_wr  out  1  instruction memory write strobe
cpu_m_addr  in  ADDR_W  CPU dmem address
cpu_m_wr_data  in  DATA_W  CPU dmem write data
cpu_m_rd  in  1  CPU dmem read
cpu_m_wr  in  1  CPU dmem write
cpu_m_en  in  1  CPU dmem enable
dmem_addr  out  ADDR_W  muxed dmem address
dmem_wdata  out  DATA_W  muxed dmem write data
dmem_rd  out  1  muxed dmem read
dmem_wr  out  1  muxed dmem write
dmem_en  out  1  muxed dmem enable
dmem_rdata  in  DATA_W  dmem read data, valid one cycle after an enabled read
cpu_halted  in  1  CPU halt indication
cpu_reset_  out  1  CPU reset, active low
busy  out  1  high in any state except IDLE and DONE
done  out  1  high in DONE

Behaviour:
- States: IDLE, LOAD_I, LOAD_D, COOL, RUN, DUMP_RD, DUMP_CAP, DUMP_OUT, DONE.
- Reset (also mid-session):
  - State returns to IDLE; all counters clear.
  - cpu_reset_=0; in_ready=0; out_valid=0; out_data=0; imem_wr=0; dmem_rd/wr/en=0; done=0; busy=0.
  - Any partially loaded or dumped data is abandoned.
- IDLE/DONE, on start=1:
  - Latch imem_len and dmem_len.
  - Go to LOAD_I; if imem_len=0, go to LOAD_D; if both are 0, go to COOL.
  - done deasserts in the same cycle.
- LOAD_I:
  - in_ready=1.
  - Each accept (in_valid&in_ready) drives imem_wr=1, imem_addr=icnt, imem_wdata=in_data combinationally in that same cycle; icnt increments.
  - After the accept with icnt=imem_len-1, go to LOAD_D (or COOL if dmem_len=0).
- LOAD_D:
  - Same handshake as LOAD_I.
  - Drives dmem_wr=1, dmem_en=1, dmem_addr=DMEM_BASE+dcnt; the address wraps modulo 2^ADDR_W.
  - After the last accept, go to COOL.
- No input is accepted outside LOAD_I and LOAD_D (in_ready=0).
- COOL:
  - cpu_reset_=0; the counter runs COOLOFF cycles.
  - Go to RUN; cpu_reset_ rises on the first RUN cycle.
- RUN:
  - cpu_reset_=1; dmem_* mirror cpu_m_* combinationally.
  - On cpu_halted=1, go to DUMP_RD with daddr=DMEM_BASE. cpu_reset_ stays 1; the halted CPU issues no accesses.
- DUMP_RD: dmem_en=1, dmem_rd=1, dmem_addr=daddr; go to DUMP_CAP.
- DUMP_CAP: register dmem_rdata into out_data; go to DUMP_OUT.
- DUMP_OUT:
  - out_valid=1; out_data stays stable until out_ready.
  - On handshake, daddr++. If daddr=DMEM_LIMIT-1, go to DONE; otherwise go to DUMP_RD.
  - Throughput is one byte per 3 cycles.
- DONE: cpu_reset_ returns to 0; done=1.
- Outside RUN, the dmem_* outputs are driven only by the controller; CPU requests are ignored.
- Simultaneous start and reset: reset wins.
- in_valid with no ready is held by the host; no byte is dropped.

Test Plan:
- Load 3 imem bytes (A0,A1,A2) and 2 dmem bytes (11,22) with in_valid held high -> imem writes at 0,1,2 on consecutive cycles; dmem writes at 8,9; cpu_reset_ rises exactly COOLOFF cycles after the last accept.
- imem_len=0, dmem_len=0, start -> IDLE→COOL directly; no imem_wr or dmem_wr pulses.
- RUN with a CPU model writing 5A to address 20, then asserting cpu_halted -> dmem_* mirror the CPU in RUN; the dump emits DMEM_LIMIT-8 bytes in address order with byte index 12 = 5A; done rises after the final handshake.
- out_ready held low for 10 cycles mid-dump -> out_valid and out_data stay stable for 10 cycles; no address is skipped or repeated.
- reset pulsed during LOAD_D after 1 of 2 bytes -> next cycle: IDLE, cpu_reset_=0, in_ready=0; a new start reloads from imem address 0.
- in_valid toggling 1/0 every cycle during LOAD_I -> writes occur only on in_valid cycles; the address count stays contiguous.

Source files
------------

// File: rtl/mem_boot_ctrl.sv
// mem_boot_ctrl: loads imem/dmem from a host byte stream, runs the CPU until halt,
// then streams the dmem window [DMEM_BASE, DMEM_LIMIT) back out to the host.
module mem_boot_ctrl #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 8,
    parameter int DMEM_BASE  = 8,
    parameter int DMEM_LIMIT = 2048,
    parameter int COOLOFF    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] imem_len,
    input  logic [ADDR_W-1:0] dmem_len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              imem_wr,
    input  logic [ADDR_W-1:0] cpu_m_addr,
    input  logic [DATA_W-1:0] cpu_m_wr_data,
    input  logic              cpu_m_rd,
    input  logic              cpu_m_wr,
    input  logic              cpu_m_en,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic              dmem_rd,
    output logic              dmem_wr,
    output logic              dmem_en,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              cpu_halted,
    output logic              cpu_reset_,
    output logic              busy,
    output logic              done
);
    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_LOAD_I   = 4'd1;
    localparam logic [3:0] S_LOAD_D   = 4'd2;
    localparam logic [3:0] S_COOL     = 4'd3;
    localparam logic [3:0] S_RUN      = 4'd4;
    localparam logic [3:0] S_DUMP_RD  = 4'd5;
    localparam logic [3:0] S_DUMP_CAP = 4'd6;
    localparam logic [3:0] S_DUMP_OUT = 4'd7;
    localparam logic [3:0] S_DONE     = 4'd8;

    logic [3:0]        r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] r_ilen;
    logic [ADDR_W-1:0] r_dlen;
    logic [ADDR_W-1:0] r_daddr;
    logic [DATA_W-1:0] r_out_data;
    logic              w_acc;
    logic              w_run;
    logic              w_ld;
    logic              w_rd;

    assign in_ready = (r_state == S_LOAD_I) || (r_state == S_LOAD_D);
    assign w_acc    = in_valid && in_ready;
    assign w_run    = r_state == S_RUN;
    assign w_ld     = (r_state == S_LOAD_D) && in_valid;
    assign w_rd     = r_state == S_DUMP_RD;

    // r_cnt is shared: imem index, dmem index, then cool-off timer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_ilen     <= '0;
            r_dlen     <= '0;
            r_daddr    <= '0;
            r_out_data <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: if (start) begin
                    r_ilen  <= imem_len;
                    r_dlen  <= dmem_len;
                    r_cnt   <= '0;
                    r_state <= (imem_len != '0) ? S_LOAD_I : (dmem_len != '0) ? S_LOAD_D : S_COOL;
                end
                S_LOAD_I: if (w_acc) begin
                    r_cnt   <= (r_cnt == r_ilen - 1'b1) ? '0 : r_cnt + 1'b1;
                    r_state <= (r_cnt != r_ilen - 1'b1) ? S_LOAD_I : (r_dlen != '0) ? S_LOAD_D : S_COOL;
                end
                S_LOAD_D: if (w_acc) begin
                    r_cnt   <= (r_cnt == r_dlen - 1'b1) ? '0 : r_cnt + 1'b1;
                    r_state <= (r_cnt == r_dlen - 1'b1) ? S_COOL : S_LOAD_D;
                end
                S_COOL: begin
                    r_cnt   <= (r_cnt == ADDR_W'(COOLOFF - 1)) ? '0 : r_cnt + 1'b1;
                    r_state <= (r_cnt == ADDR_W'(COOLOFF - 1)) ? S_RUN : S_COOL;
                end
                S_RUN: if (cpu_halted) begin
                    r_daddr <= ADDR_W'(DMEM_BASE);
                    r_state <= S_DUMP_RD;
                end
                S_DUMP_RD: r_state <= S_DUMP_CAP;
                S_DUMP_CAP: begin
                    r_out_data <= dmem_rdata;
                    r_state    <= S_DUMP_OUT;
                end
                S_DUMP_OUT: if (out_ready) begin
                    r_daddr <= r_daddr + 1'b1;
                    r_state <= (r_daddr == ADDR_W'(DMEM_LIMIT - 1)) ? S_DONE : S_DUMP_RD;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign imem_wr    = (r_state == S_LOAD_I) && in_valid;
    assign imem_addr  = r_cnt;
    assign imem_wdata = in_data;

    // the CPU sees dmem only while running; elsewhere the controller owns the port
    assign dmem_addr  = w_run ? cpu_m_addr : w_rd ? r_daddr : ADDR_W'(DMEM_BASE) + r_cnt;
    assign dmem_wdata = w_run ? cpu_m_wr_data : in_data;
    assign dmem_rd    = w_run ? cpu_m_rd : w_rd;
    assign dmem_wr    = w_run ? cpu_m_wr : w_ld;
    assign dmem_en    = w_run ? cpu_m_en : (w_ld || w_rd);

    assign out_valid  = r_state == S_DUMP_OUT;
    assign out_data   = r_out_data;
    assign cpu_reset_ = (r_state == S_RUN) || (r_state == S_DUMP_RD) ||
                        (r_state == S_DUMP_CAP) || (r_state == S_DUMP_OUT);
    assign busy       = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done       = r_state == S_DONE;
endmodule

// File: tb/tb_mem_boot_ctrl.sv
// tb_mem_boot_ctrl: phase-level model of a load/run/dump session checked every cycle,
// plus directed literal checks on cool-off timing, dump contents and reset behaviour.
module tb_mem_boot_ctrl;
    localparam int AW = 12, DW = 8, BASE = 8, LIM = 2048, CO = 32;
    localparam int P_IDLE = 0, P_LOAD = 1, P_COOL = 2, P_RUN = 3, P_DUMP = 4, P_DONE = 5;

    logic clk = 0, reset = 1, start = 0;
    logic [AW-1:0] imem_len = 0, dmem_len = 0;
    logic in_valid = 0, in_ready, out_valid, out_ready = 1;
    logic [DW-1:0] in_data = 0, out_data;
    logic [AW-1:0] imem_addr, cpu_m_addr = 0, dmem_addr;
    logic [DW-1:0] imem_wdata, cpu_m_wr_data = 0, dmem_wdata, dmem_rdata;
    logic imem_wr, cpu_m_rd = 0, cpu_m_wr = 0, cpu_m_en = 0;
    logic dmem_rd, dmem_wr, dmem_en, cpu_halted = 0, cpu_reset_, busy, done;

    mem_boot_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DMEM_BASE(BASE), .DMEM_LIMIT(LIM), .COOLOFF(CO)) dut (
        .clk(clk), .reset(reset), .start(start), .imem_len(imem_len), .dmem_len(dmem_len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .imem_wr(imem_wr),
        .cpu_m_addr(cpu_m_addr), .cpu_m_wr_data(cpu_m_wr_data), .cpu_m_rd(cpu_m_rd),
        .cpu_m_wr(cpu_m_wr), .cpu_m_en(cpu_m_en),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rd(dmem_rd), .dmem_wr(dmem_wr),
        .dmem_en(dmem_en), .dmem_rdata(dmem_rdata), .cpu_halted(cpu_halted),
        .cpu_reset_(cpu_reset_), .busy(busy), .done(done));

    always #5 clk = ~clk;

    logic [7:0] dmem_m [0:4095];
    logic [7:0] imem_m [0:4095];
    logic [7:0] exp_mem [0:4095];
    logic [7:0] dumped [0:2047];
    logic [7:0] rd_q;
    assign dmem_rdata = rd_q;

    always @(posedge clk) begin
        if (imem_wr) imem_m[imem_addr] <= imem_wdata;
        if (reset) for (int a = 0; a < 4096; a++) dmem_m[a] <= 8'(a) ^ 8'h3C;
        else if (dmem_en && dmem_wr) dmem_m[dmem_addr] <= dmem_wdata;
        if (dmem_en && dmem_rd) rd_q <= dmem_m[dmem_addr];
    end

    int n_chk = 0, n_err = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    int m_phase = P_IDLE, m_acc = 0, m_tot = 0, m_ilen = 0, m_cool = 0, m_daddr = 0, m_cnt = 0;
    logic prev_ov = 0, prev_or = 0;
    logic [7:0] prev_od = 0;

    always @(negedge clk) begin
        logic acc;
        acc = in_valid && in_ready;
        chk("busy", 32'(busy), 32'(m_phase != P_IDLE && m_phase != P_DONE));
        chk("done", 32'(done), 32'(m_phase == P_DONE));
        chk("cpu_reset_", 32'(cpu_reset_), 32'(m_phase == P_RUN || m_phase == P_DUMP));
        chk("in_ready", 32'(in_ready), 32'(m_phase == P_LOAD));
        if (m_phase == P_LOAD && acc) begin
            if (m_acc < m_ilen) begin
                chk("imem_wr", 32'(imem_wr), 1);
                chk("imem_addr", 32'(imem_addr), 32'(m_acc));
                chk("imem_wdata", 32'(imem_wdata), 32'(in_data));
                chk("dmem_en_iload", 32'(dmem_en), 0);
            end else begin
                chk("dmem_wr_load", 32'(dmem_wr), 1);
                chk("dmem_en_load", 32'(dmem_en), 1);
                chk("dmem_addr_load", 32'(dmem_addr), 32'((BASE + m_acc - m_ilen) % 4096));
                chk("dmem_wdata_load", 32'(dmem_wdata), 32'(in_data));
                chk("imem_wr_dload", 32'(imem_wr), 0);
            end
        end else if (m_phase != P_RUN) begin
            chk("imem_wr_idle", 32'(imem_wr), 0);
            if (m_phase != P_DUMP) chk("dmem_en_idle", 32'(dmem_en), 0);
        end
        if (m_phase == P_RUN) begin
            chk("mirror_addr", 32'(dmem_addr), 32'(cpu_m_addr));
            chk("mirror_wdata", 32'(dmem_wdata), 32'(cpu_m_wr_data));
            chk("mirror_rd", 32'(dmem_rd), 32'(cpu_m_rd));
            chk("mirror_wr", 32'(dmem_wr), 32'(cpu_m_wr));
            chk("mirror_en", 32'(dmem_en), 32'(cpu_m_en));
            chk("imem_wr_run", 32'(imem_wr), 0);
        end
        if (m_phase == P_DUMP) begin
            chk("dmem_wr_dump", 32'(dmem_wr), 0);
            if (dmem_rd) begin
                chk("dump_rd_addr", 32'(dmem_addr), 32'(m_daddr));
                chk("dump_rd_en", 32'(dmem_en), 1);
            end
            if (prev_ov && !prev_or) begin
                chk("stall_valid", 32'(out_valid), 1);
                chk("stall_data", 32'(out_data), 32'(prev_od));
            end
            if (prev_ov && prev_or) chk("gap_after_byte", 32'(out_valid), 0);
            if (out_valid && out_ready) begin
                chk("dump_byte", 32'(out_data), 32'(exp_mem[m_daddr]));
                dumped[m_cnt] = out_data;
            end
        end else chk("out_valid_idle", 32'(out_valid), 0);
        prev_ov = out_valid;
        prev_or = out_ready;
        prev_od = out_data;
        if (reset) begin
            m_phase = P_IDLE;
            prev_ov = 0;
        end else case (m_phase)
            P_IDLE, P_DONE: if (start) begin
                m_ilen = int'(imem_len);
                m_tot = int'(imem_len) + int'(dmem_len);
                m_acc = 0;
                m_cool = 0;
                m_phase = (m_tot != 0) ? P_LOAD : P_COOL;
            end
            P_LOAD: if (acc) begin
                m_acc++;
                if (m_acc == m_tot) m_phase = P_COOL;
            end
            P_COOL: begin
                m_cool++;
                if (m_cool == CO) m_phase = P_RUN;
            end
            P_RUN: if (cpu_halted) begin
                m_phase = P_DUMP;
                m_daddr = BASE;
                m_cnt = 0;
            end
            P_DUMP: if (out_valid && out_ready) begin
                m_cnt++;
                if (m_daddr == LIM - 1) m_phase = P_DONE;
                m_daddr++;
            end
            default: m_phase = P_IDLE;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input int il, input int dl);
        tick();
        start = 1;
        imem_len = AW'(il);
        dmem_len = AW'(dl);
        tick();
        start = 0;
    endtask

    task automatic send(input logic [7:0] b, input bit gap);
        bit ok;
        ok = 0;
        in_valid = 1;
        in_data = b;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = in_ready;
            tick();
        end
        in_valid = 0;
        if (!ok) chk("send_timeout", 0, 1);
        if (gap) tick();
    endtask

    task automatic pulse_reset();
        tick();
        reset = 1;
        tick();
        reset = 0;
    endtask

    initial begin
        int n, st, pulses;
        for (int a = 0; a < 4096; a++) exp_mem[a] = 8'(a) ^ 8'h3C;
        repeat (3) tick();
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_imem_wr", 32'(imem_wr), 0);
        chk("rst_dmem_en", 32'({dmem_en, dmem_rd, dmem_wr}), 0);
        chk("rst_cpu_reset_", 32'(cpu_reset_), 0);
        chk("rst_busy_done", 32'({busy, done}), 0);
        reset = 0;

        exp_mem[8] = 8'h11;
        exp_mem[9] = 8'h22;
        cpu_m_en = 1; cpu_m_wr = 1; cpu_m_addr = 30; cpu_m_wr_data = 8'hFF;
        go(3, 2);
        send(8'hA0, 0); send(8'hA1, 0); send(8'hA2, 0); send(8'h11, 0); send(8'h22, 0);
        cpu_m_en = 0; cpu_m_wr = 0;
        n = 0;
        while (!cpu_reset_ && n < 200) begin tick(); n++; end
        chk("cooloff_cycles", 32'(n), 32'(CO));
        cpu_m_en = 1; cpu_m_wr = 1; cpu_m_addr = 20; cpu_m_wr_data = 8'h5A;
        exp_mem[20] = 8'h5A;
        tick();
        cpu_m_wr = 0; cpu_m_rd = 1; cpu_m_addr = 9;
        tick();
        cpu_m_rd = 0; cpu_m_en = 0; cpu_halted = 1;
        tick();
        out_ready = 1;
        for (int k = 0; k < 2000 && m_cnt < 100; k++) tick();
        out_ready = 0;
        st = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) st++;
        end
        tick();
        out_ready = 1;
        chk("stall_cycles", 32'(st), 10);
        for (int k = 0; k < 20000 && m_phase != P_DONE; k++) tick();
        chk("done_after_dump", 32'(done), 1);
        chk("dump_count", 32'(m_cnt), 32'(LIM - BASE));
        chk("dump_idx0", 32'(dumped[0]), 32'h11);
        chk("dump_idx1", 32'(dumped[1]), 32'h22);
        chk("dump_idx12", 32'(dumped[12]), 32'h5A);
        chk("dump_idx22_cpu_ignored", 32'(dumped[22]), 32'h22);
        chk("imem_0", 32'(imem_m[0]), 32'hA0);
        chk("imem_2", 32'(imem_m[2]), 32'hA2);

        cpu_halted = 0;
        go(0, 0);
        chk("zero_len_busy", 32'(busy), 1);
        chk("zero_len_no_ready", 32'(in_ready), 0);
        n = 0;
        pulses = 0;
        while (!cpu_reset_ && n < 200) begin
            tick();
            n++;
            if (imem_wr || dmem_wr) pulses++;
        end
        chk("zero_len_cool", 32'(n), 32'(CO));
        chk("zero_len_no_writes", 32'(pulses), 0);
        pulse_reset();

        go(2, 2);
        send(8'hB0, 0); send(8'hB1, 0); send(8'h33, 0);
        reset = 1;
        tick();
        chk("abort_busy", 32'(busy), 0);
        chk("abort_cpu_reset_", 32'(cpu_reset_), 0);
        chk("abort_in_ready", 32'(in_ready), 0);
        reset = 0;
        go(4, 0);
        send(8'hC0, 1); send(8'hC1, 1); send(8'hC2, 1); send(8'hC3, 1);
        chk("reload_imem0", 32'(imem_m[0]), 32'hC0);
        chk("reload_imem1", 32'(imem_m[1]), 32'hC1);
        chk("reload_imem3", 32'(imem_m[3]), 32'hC3);
        chk("reload_in_cool", 32'({busy, in_ready, cpu_reset_}), 32'b100);
        pulse_reset();
        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
